uart_rx_ctrl: RTL and testbench

Controller that sequences the UART receiver datapath for the RISC-V core.
- Gates the receiver enable (rx_re) using software control and FIFO space.
- Captures each received byte (rx_valid pulse) into a DEPTH-entry FIFO.
- Exposes DATA/STATUS/CTRL registers on the CPU peripheral bus, with sticky overrun and optional interrupt.

---
 rtl/uart_rx_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates rx_re, buffers received bytes in a DEPTH-entry FIFO, exposes DATA/STATUS/CTRL.
// Optional feature macro UART_RX_IRQ_EN adds CTRL.irq_en and the level interrupt on irq.
module uart_rx_ctrl #(
    parameter int unsigned  DEPTH         = 16,
    parameter int unsigned  IRQ_THRESHOLD = 1,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rx_re,
    input  logic [7:0]  rx_dout,
    input  logic        rx_valid,
    output logic        irq
);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [1:0]    A_DATA   = 2'd0;
    localparam logic [1:0]    A_STATUS = 2'd1;
    localparam logic [1:0]    A_CTRL   = 2'd2;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        IRQ_THRESHOLD < 1 || IRQ_THRESHOLD > DEPTH) begin : g_param_check
        $error("uart_rx_ctrl: illegal DEPTH or IRQ_THRESHOLD");
    end

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic          r_en;
    logic          r_rx_re;
    logic [31:0]   r_rdata;

    logic          w_empty;
    logic          w_full;
    logic          w_rd;
    logic          w_wr;
    logic          w_pop;
    logic          w_push;
    logic          w_ovr_set;
    logic          w_ovr_nxt;
    logic          w_en_nxt;
    logic          w_irq_en;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_status;
    logic [31:0]   w_ctrl;
    logic [31:0]   w_rdata_nxt;
    logic          w_unused;

    // Only the low control bits of wdata are decoded.
    assign w_unused = ^wdata;

    // FIFO handshake, register decode and next-state values.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == DEPTH_C);
        w_rd        = sel && !we;
        w_wr        = sel && we;
        w_pop       = w_rd && (addr == A_DATA) && !w_empty;
        w_push      = rx_valid && (!w_full || w_pop);
        w_ovr_set   = rx_valid && !w_push;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
        // A new overrun in the same cycle beats the W1C clear.
        w_ovr_nxt   = w_ovr_set || (r_overrun && !(w_wr && (addr == A_STATUS) && wdata[2]));
        w_en_nxt    = (w_wr && (addr == A_CTRL)) ? wdata[0] : r_en;
        w_status    = {16'd0, 8'(r_count), 5'd0, r_overrun, w_full, !w_empty};
        w_ctrl      = {30'd0, w_irq_en, r_en};
        w_rdata_nxt = r_rdata;
        if (w_rd) begin
            case (addr)
                A_DATA:   w_rdata_nxt = w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
                A_STATUS: w_rdata_nxt = w_status;
                A_CTRL:   w_rdata_nxt = w_ctrl;
                default:  w_rdata_nxt = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_en      <= 1'b0;
            r_rx_re   <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            r_overrun <= w_ovr_nxt;
            r_en      <= w_en_nxt;
            r_rx_re   <= w_en_nxt && (w_count_nxt < DEPTH_C);
            r_rdata   <= w_rdata_nxt;
        end
    end

    // Storage needs no reset; reads of an empty FIFO are masked to zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_dout;
        end
    end

`ifdef UART_RX_IRQ_EN
    localparam logic [CW-1:0] THR_C = CW'(IRQ_THRESHOLD);

    logic r_irq_en;
    logic r_irq;
    logic w_irq_en_nxt;

    always_comb begin
        w_irq_en_nxt = (w_wr && (addr == A_CTRL)) ? wdata[1] : r_irq_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= w_irq_en_nxt && ((w_count_nxt >= THR_C) || w_ovr_nxt);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    assign rdata = r_rdata;
    assign rx_re = r_rx_re;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus/receiver traffic.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int THR   = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        sel      = 1'b0;
    logic        we       = 1'b0;
    logic [1:0]  addr     = 2'd0;
    logic [31:0] wdata    = 32'd0;
    logic [31:0] rdata;
    logic        rx_re;
    logic [7:0]  rx_dout  = 8'd0;
    logic        rx_valid = 1'b0;
    logic        irq;

    uart_rx_ctrl #(.DEPTH(DEPTH), .IRQ_THRESHOLD(THR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rx_re    (rx_re),
        .rx_dout  (rx_dout),
        .rx_valid (rx_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    byte unsigned q[$];
    logic         m_ovr;
    logic         m_en;
    logic         m_irq_en;
    logic         m_rx_re;
    logic         m_irq;
    logic [31:0]  m_rdata;

    int n_checks;
    int n_fail;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr    = 1'b0;
        m_en     = 1'b0;
        m_irq_en = 1'b0;
        m_rx_re  = 1'b0;
        m_irq    = 1'b0;
        m_rdata  = 32'd0;
    endtask

    // One clock of the model: read from pre-state, apply writes, then push.
    task automatic model_update();
        int sz;
        sz = q.size();
        if (sel && !we) begin
            case (addr)
                2'd0: begin
                    if (sz > 0) m_rdata = {24'd0, q.pop_front()};
                    else        m_rdata = 32'd0;
                end
                2'd1:    m_rdata = {16'd0, 8'(sz), 5'd0, m_ovr, (sz == DEPTH), (sz != 0)};
                2'd2:    m_rdata = {30'd0, m_irq_en, m_en};
                default: m_rdata = 32'd0;
            endcase
        end
        if (sel && we && addr == 2'd1 && wdata[2]) m_ovr = 1'b0;
        if (sel && we && addr == 2'd2) begin
            m_en = wdata[0];
`ifdef UART_RX_IRQ_EN
            m_irq_en = wdata[1];
`endif
        end
        if (rx_valid) begin
            if (q.size() < DEPTH) q.push_back(rx_dout);
            else                  m_ovr = 1'b1;
        end
        m_rx_re = m_en && (q.size() < DEPTH);
`ifdef UART_RX_IRQ_EN
        m_irq = m_irq_en && ((q.size() >= THR) || m_ovr);
`else
        m_irq = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("rdata", rdata, m_rdata);
        check("rx_re", {31'd0, rx_re}, {31'd0, m_rx_re});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic cyc(input logic s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic v, input logic [7:0] b);
        sel = s; we = w; addr = a; wdata = d; rx_valid = v; rx_dout = b;
        step();
        sel = 1'b0; we = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, 8'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0, 8'd0);
    endtask

    task automatic push(input logic [7:0] b);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, b);
    endtask

    task automatic do_reset();
        sel = 1'b0; we = 1'b0; rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_rx_re", {31'd0, rx_re}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic        s, w, v;
        logic [1:0]  a;
        logic [31:0] d;
        int          r;

        n_checks = 0;
        n_fail   = 0;
        do_reset();

        // Basic enable, single byte, read back
        wr(2'd2, 32'h1);
        check("t1_rx_re", {31'd0, rx_re}, 32'd1);
        push(8'hA5);
        rd(2'd1); check("t1_status", rdata, 32'h0000_0101);
        rd(2'd0); check("t1_data", rdata, 32'h0000_00A5);
        rd(2'd1); check("t1_status_empty", rdata, 32'h0000_0000);

        // Fill, overrun, drain, W1C
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_rx_re_full", {31'd0, rx_re}, 32'd0);
        push(8'h55);
        rd(2'd1); check("t2_status_ovr", rdata, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0);
            check("t2_data", rdata, 32'(i));
        end
        wr(2'd1, 32'h4);
        rd(2'd1); check("t2_status_clr", rdata, 32'h0000_0000);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 8'h77);
        check("t3_pop_head", rdata, 32'h0000_0010);
        rd(2'd1); check("t3_status", rdata, 32'h0000_1003);
        check("t3_rx_re", {31'd0, rx_re}, 32'd0);
        for (int i = 0; i < 16; i++) rd(2'd0);
        check("t3_last", rdata, 32'h0000_0077);

        // Empty read, then pointer wrap
        rd(2'd0); check("t4_empty_data", rdata, 32'd0);
        rd(2'd1); check("t4_empty_status", rdata, 32'd0);
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h80 + i));
            rd(2'd0);
            check("t4_wrap", rdata, 32'(8'(8'h80 + i)));
        end

        // Disable while a frame is in flight, then reset with data pending
        wr(2'd2, 32'h1);
        wr(2'd2, 32'h0);
        push(8'h3C);
        check("t5_rx_re", {31'd0, rx_re}, 32'd0);
        rd(2'd1); check("t5_status", rdata, 32'h0000_0101);
        push(8'h11);
        do_reset();
        rd(2'd1); check("t5_rst_status", rdata, 32'd0);
        rd(2'd2); check("t5_rst_ctrl", rdata, 32'd0);

        // Interrupt threshold
        do_reset();
        wr(2'd2, 32'h3);
        for (int i = 0; i < 3; i++) push(8'(i));
        check("t6_irq_below", {31'd0, irq}, 32'd0);
        push(8'h03);
`ifdef UART_RX_IRQ_EN
        check("t6_irq_at", {31'd0, irq}, 32'd1);
`else
        check("t6_irq_at", {31'd0, irq}, 32'd0);
`endif
        rd(2'd0);
        check("t6_irq_after_pop", {31'd0, irq}, 32'd0);
        rd(2'd2);
`ifdef UART_RX_IRQ_EN
        check("t6_ctrl", rdata, 32'h3);
`else
        check("t6_ctrl", rdata, 32'h1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            v = ($urandom_range(0, 9) < 4);
            d = $urandom;
            s = 1'b1; w = 1'b0; a = 2'd0;
            case (r)
                0, 1, 2, 3: begin w = 1'b0; a = 2'd0; end
                4:          begin w = 1'b0; a = 2'd1; end
                5:          begin w = 1'b0; a = 2'd2; end
                6:          begin w = 1'b1; a = 2'd1; end
                7:          begin w = 1'b1; a = 2'd2; end
                8:          begin w = $urandom_range(0, 1) == 1; a = 2'($urandom_range(0, 3)); end
                default:    s = 1'b0;
            endcase
            cyc(s, w, a, d, v, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
